fft_reorder: RTL and testbench
==============================

FFT_REORDER -- requirements
Module: fft_reorder

Interface
REQ-001 Parameter N_pt, 128, FFT frame length in samples; power of two.
REQ-002 Parameter BW, 16, sample width per real/imaginary component.
REQ-003 Parameter ADDR_W, $clog2(N_pt), buffer address width (7).
REQ-004 The clock port SHALL be `clk`  input  1  rising-edge clock for all state.
REQ-005 The reset port SHALL be `reset_n`  input  1  asynchronous, active-low reset.
REQ-006 valid  input  1  inReal/inImag carry an FFT output sample this cycle.
REQ-007 start  input  1  qualified by valid; marks sample index 0 of a bit-reversed frame.
REQ-008 inReal  input  BW  real part from the last FFT stage, two's complement.
REQ-009 inImag  input  BW  imaginary part from the last FFT stage, two's complement.
REQ-010 outReal  output  BW  real part in natural frequency order.
REQ-011 outImag  output  BW  imaginary part in natural frequency order.
REQ-012 out_valid  output  1  outReal/outImag hold a valid bin this cycle.
REQ-013 out_start  output  1  high with out_valid on bin 0 of each frame.

Function
REQ-014 Storage SHALL be a ping-pong buffer of 2 banks x N_pt entries x 2*BW bits.
REQ-015 The write side SHALL store each valid sample at address wr_cnt in the write bank, then increment wr_cnt, wrapping N_pt-1 -> 0.
REQ-016 valid && start SHALL write at address 0, set wr_cnt to 1, and discard any partial frame in the write bank.
REQ-017 A write at address N_pt-1 SHALL toggle the write bank and hand the filled bank to the read side.
REQ-018 The read side SHALL be a 2-state FSM, IDLE and READ; a bank handoff in IDLE moves to READ with rd_cnt=0.
REQ-019 In READ, each cycle SHALL read address bitrev(rd_cnt), where bitrev reverses the ADDR_W bits, then increment rd_cnt. Reading SHALL be continuous and independent of valid.
REQ-020 After rd_cnt=N_pt-1, the FSM SHALL return to IDLE, or stay in READ with rd_cnt=0 if a new handoff is pending or arrives in that cycle, with no gap cycle.
REQ-021 Latency: if the last sample of a frame is written in cycle T, bin 0 SHALL appear with out_valid=out_start=1 in cycle T+2, and bin k in cycle T+2+k.
REQ-022 Outputs SHALL be registered. When out_valid=0, outReal/outImag SHALL hold their last value.
REQ-023 No arithmetic SHALL be applied; data width in equals data width out.
REQ-024 A start arriving while a bank is being read SHALL not disturb that read.
REQ-025 Valid gaps of any length SHALL only stall the write side.

Reset
REQ-026 reset_n=0 SHALL asynchronously clear wr_cnt, rd_cnt, bank selects, pending handoff, FSM (to IDLE), out_valid, out_start, outReal and outImag to 0.
REQ-027 Buffer contents need not be reset.
REQ-028 Reset mid-frame SHALL drop both banks; no output SHALL appear until a complete new frame is written.

Structure
REQ-029 Package fft_pkg SHALL hold N_pt, ADDR_W, BW defaults and the bitrev function.
REQ-030 A single sub-module fft_dp_ram (one write port, one registered read port) SHALL implement each bank. All control stays in fft_reorder.

Verification
REQ-031 Write one frame with start on index 0 and sample n = (n, -n), valid every cycle. Expected: bin k outputs (bitrev(k), -bitrev(k)); bin 1 = (64,-64); out_start only on bin 0; last write at cycle T gives out_valid cycles T+2..T+129.
REQ-032 Send three back-to-back frames with valid always high. Expected: out_valid stays high continuously for 384 cycles after the first T+2, and out_start pulses every 128 cycles.
REQ-033 Drive valid with a 1-on/1-off pattern. Expected: output is identical in order and values to REQ-031, starting 2 cycles after the 128th write.
REQ-034 Write 50 samples, then send start with fresh frame data. Expected: the output holds only the fresh frame; none of the 50 stale samples appear.
REQ-035 Assert reset_n=0 at read bin 60. Expected: all outputs are 0 immediately, and there is no output until the next full frame.
REQ-036 Send start while bank A is being read. Expected: bank A's output is unchanged and bank B's output follows with no gap.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared defaults, read FSM states and bit-reversal helper for fft_reorder
package fft_pkg;

    localparam int N_PT_DEFAULT   = 128;
    localparam int BW_DEFAULT     = 16;
    localparam int ADDR_W_DEFAULT = $clog2(N_PT_DEFAULT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } rd_state_t;

    // Reverse the low w bits of a; bits at and above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] a, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) begin
                r[i] = a[w-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_dp_ram.sv
// rtl/fft_dp_ram.sv - one buffer bank: single write port, registered read port
module fft_dp_ram
    import fft_pkg::*;
#(
    parameter int DEPTH = N_PT_DEFAULT,
    parameter int AW    = ADDR_W_DEFAULT,
    parameter int DW    = 2 * BW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Sample storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register only loads when this bank is being read, so it holds otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_reorder.sv
// rtl/fft_reorder.sv - ping-pong buffer turning bit-reversed FFT output into natural order
module fft_reorder
    import fft_pkg::*;
#(
    parameter int N_pt   = N_PT_DEFAULT,
    parameter int BW     = BW_DEFAULT,
    parameter int ADDR_W = $clog2(N_pt)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          valid,
    input  logic          start,
    input  logic [BW-1:0] inReal,
    input  logic [BW-1:0] inImag,
    output logic [BW-1:0] outReal,
    output logic [BW-1:0] outImag,
    output logic          out_valid,
    output logic          out_start
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_pt - 1);

    logic [ADDR_W-1:0] wr_cnt;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_last;

    rd_state_t         state;
    logic [ADDR_W-1:0] rd_cnt;
    logic              rd_bank;
    logic              pend;
    logic              pend_bank;
    logic              out_sel;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_last;

    logic [2*BW-1:0]   q0;
    logic [2*BW-1:0]   q1;

    // A start forces address 0, which implicitly drops any partial frame.
    assign wr_addr = start ? '0 : wr_cnt;
    assign wr_last = valid && (wr_addr == LAST_ADDR);
    assign rd_addr = ADDR_W'(bitrev(32'(rd_cnt), ADDR_W));
    assign rd_last = (rd_cnt == LAST_ADDR);

    // Write side: count valid samples and swap banks after the last one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (valid) begin
            wr_cnt <= wr_addr + 1'b1;
            if (wr_last) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Read FSM: sweep a handed-off bank in bit-reversed order, chaining frames without gaps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            rd_cnt    <= '0;
            rd_bank   <= 1'b0;
            pend      <= 1'b0;
            pend_bank <= 1'b0;
            out_valid <= 1'b0;
            out_start <= 1'b0;
            out_sel   <= 1'b0;
        end else begin
            out_valid <= (state == ST_READ);
            out_start <= (state == ST_READ) && (rd_cnt == '0);
            if (state == ST_READ) begin
                out_sel <= rd_bank;
            end
            case (state)
                ST_IDLE: begin
                    if (wr_last) begin
                        state   <= ST_READ;
                        rd_cnt  <= '0;
                        rd_bank <= wr_bank;
                    end
                end
                ST_READ: begin
                    rd_cnt <= rd_cnt + 1'b1;
                    if (rd_last) begin
                        if (pend) begin
                            rd_bank   <= pend_bank;
                            pend      <= wr_last;
                            pend_bank <= wr_bank;
                        end else if (wr_last) begin
                            rd_bank <= wr_bank;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (wr_last) begin
                        pend      <= 1'b1;
                        pend_bank <= wr_bank;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fft_dp_ram #(.DEPTH(N_pt), .AW(ADDR_W), .DW(2*BW)) u_bank0 (
        .clk    (clk),
        .reset_n(reset_n),
        .we     (valid && !wr_bank),
        .waddr  (wr_addr),
        .wdata  ({inReal, inImag}),
        .re     ((state == ST_READ) && !rd_bank),
        .raddr  (rd_addr),
        .rdata  (q0)
    );

    fft_dp_ram #(.DEPTH(N_pt), .AW(ADDR_W), .DW(2*BW)) u_bank1 (
        .clk    (clk),
        .reset_n(reset_n),
        .we     (valid && wr_bank),
        .waddr  (wr_addr),
        .wdata  ({inReal, inImag}),
        .re     ((state == ST_READ) && rd_bank),
        .raddr  (rd_addr),
        .rdata  (q1)
    );

    assign {outReal, outImag} = out_sel ? q1 : q0;

endmodule

// File: tb/tb_fft_reorder.sv
// tb/tb_fft_reorder.sv - scoreboard bench for fft_reorder
module tb_fft_reorder;

    localparam int N  = 128;
    localparam int BW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          valid = 1'b0;
    logic          start = 1'b0;
    logic [BW-1:0] inReal = '0;
    logic [BW-1:0] inImag = '0;
    logic [BW-1:0] outReal;
    logic [BW-1:0] outImag;
    logic          out_valid;
    logic          out_start;

    fft_reorder #(.N_pt(N), .BW(BW), .ADDR_W(7)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .valid    (valid),
        .start    (start),
        .inReal   (inReal),
        .inImag   (inImag),
        .outReal  (outReal),
        .outImag  (outImag),
        .out_valid(out_valid),
        .out_start(out_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] re;
        logic [BW-1:0] im;
        logic          st;
        int            due;
    } exp_t;

    exp_t          sbq[$];
    int            compared = 0;
    int            mismatched = 0;
    int            cyc = 0;
    int            bins_seen = 0;
    logic [BW-1:0] mr[N];
    logic [BW-1:0] mi[N];
    int            mcnt = 0;
    int            ma;
    int            br;
    logic [BW-1:0] last_re = '0;
    logic [BW-1:0] last_im = '0;
    exp_t          e;
    exp_t          ne;

    function automatic int brev7(input int k);
        int r;
        r = 0;
        for (int i = 0; i < 7; i++) begin
            if (((k >> i) & 1) != 0) r = r | (1 << (6 - i));
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference frame model: when a frame completes, queue its natural-order bins with due cycles.
    always @(posedge clk) begin
        if (!reset_n) begin
            mcnt = 0;
        end else if (valid) begin
            ma = start ? 0 : mcnt;
            mr[ma] = inReal;
            mi[ma] = inImag;
            mcnt = (ma + 1) % N;
            if (ma == N - 1) begin
                for (int k = 0; k < N; k++) begin
                    br = brev7(k);
                    ne.re = mr[br];
                    ne.im = mi[br];
                    ne.st = (k == 0);
                    ne.due = cyc + 2 + k;
                    sbq.push_back(ne);
                end
            end
        end
    end

    // Monitor: pop and compare every valid output; check hold behaviour when idle.
    always @(negedge clk) begin
        if (reset_n) begin
            compared++;
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_output cyc=%0d got re=%h im=%h st=%b want no output",
                             cyc, outReal, outImag, out_start);
                end else begin
                    e = sbq.pop_front();
                    bins_seen++;
                    if (outReal !== e.re || outImag !== e.im || out_start !== e.st || cyc != e.due) begin
                        mismatched++;
                        $display("FAIL bin got re=%h im=%h st=%b cyc=%0d want re=%h im=%h st=%b cyc=%0d",
                                 outReal, outImag, out_start, cyc, e.re, e.im, e.st, e.due);
                    end
                end
                last_re = outReal;
                last_im = outImag;
            end else begin
                if (outReal !== last_re || outImag !== last_im || out_start !== 1'b0) begin
                    mismatched++;
                    $display("FAIL idle_hold cyc=%0d got re=%h im=%h st=%b want re=%h im=%h st=0",
                             cyc, outReal, outImag, out_start, last_re, last_im);
                end
            end
        end
    end

    task automatic send(input int re, input int im, input bit st);
        @(negedge clk);
        valid  = 1'b1;
        start  = st;
        inReal = BW'(re);
        inImag = BW'(im);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid = 1'b0;
            start = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int t;
        t = 0;
        while (sbq.size() != 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        compared++;
        if (sbq.size() != 0) begin
            mismatched++;
            $display("FAIL drain_%s remaining=%0d want 0", name, sbq.size());
            sbq.delete();
        end
        idle(4);
    endtask

    task automatic check_zero(input string name);
        compared++;
        if (out_valid !== 1'b0 || out_start !== 1'b0 || outReal !== '0 || outImag !== '0) begin
            mismatched++;
            $display("FAIL %s got v=%b st=%b re=%h im=%h want all 0",
                     name, out_valid, out_start, outReal, outImag);
        end
    endtask

    initial begin
        int guard;
        int target;

        // reset state
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        reset_n = 1'b1;
        idle(3);

        // single frame, sample n = (n, -n)
        for (int n = 0; n < N; n++) send(n, -n, n == 0);
        idle(1);
        wait_drain("single", 400);

        // three back-to-back frames, start only on the first
        for (int f = 0; f < 3; f++)
            for (int n = 0; n < N; n++) send(f * 300 + n, ~n ^ f, f == 0 && n == 0);
        idle(1);
        wait_drain("three", 700);

        // 1-on/1-off valid
        for (int n = 0; n < N; n++) begin
            send(n, -n, n == 0);
            idle(1);
        end
        wait_drain("gappy", 400);

        // 50 stale samples then a fresh frame
        for (int n = 0; n < 50; n++) send(16'hAA00 + n, 16'h5500 + n, n == 0);
        for (int n = 0; n < N; n++) send(n * 2, n + 7, n == 0);
        idle(1);
        wait_drain("stale", 400);

        // start arrives while bank A is read; bank B follows directly
        for (int n = 0; n < N; n++) send(16'h1000 + n, 16'h3000 - n, n == 0);
        for (int n = 0; n < N; n++) send(16'h2000 + n, 16'h4000 + 3 * n, n == 0);
        idle(1);
        wait_drain("ab", 600);

        // reset during readout at bin 60
        target = bins_seen + 61;
        for (int n = 0; n < N; n++) send(n + 5, n * 5, n == 0);
        idle(1);
        guard = 0;
        while (bins_seen < target && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        compared++;
        if (bins_seen < target) begin
            mismatched++;
            $display("FAIL reach_bin60 got bins=%0d want %0d", bins_seen, target);
        end
        #2;
        reset_n = 1'b0;
        sbq.delete();
        last_re = '0;
        last_im = '0;
        #1;
        check_zero("reset_mid_read");
        repeat (3) @(negedge clk);
        check_zero("reset_held");
        reset_n = 1'b1;
        idle(20);
        for (int n = 0; n < 60; n++) send(16'h7000 + n, n, 1'b0);
        for (int n = 0; n < N; n++) send(16'h0800 + n, 16'hF000 + n, n == 0);
        idle(1);
        wait_drain("after_reset", 400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog cyc=%0d want finish before timeout", cyc);
        $fatal(1, "timeout");
    end

endmodule
